// File: rtl/get_height.sv
// Pitch-to-height: 64-sample capture, serial DFT over bins 1..31, peak bin scaled to a screen height.
module get_height #(
  parameter int unsigned MAG_THRESH  = 4096,
  parameter int unsigned HEIGHT_STEP = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mic_clk,
  input  logic [11:0] mic_data,
  output logic [9:0]  height
);

  localparam int unsigned SMP_W = 12;
  localparam int unsigned TW_W  = 8;
  localparam int unsigned ACC_W = 28;
  localparam int unsigned HGT_W = 10;
  localparam int unsigned IDX_W = 6;
  localparam int unsigned BIN_W = 5;

  typedef enum logic [1:0] {ST_FILL, ST_COMPUTE, ST_CMP, ST_UPDATE} state_t;

  state_t             r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_cnt, w_cnt_nxt;
  logic [BIN_W-1:0]   r_k, w_k_nxt;
  logic [IDX_W-1:0]   r_n, w_n_nxt;
  logic [ACC_W-1:0]   r_re, w_re_nxt;
  logic [ACC_W-1:0]   r_im, w_im_nxt;
  logic [ACC_W-1:0]   r_max, w_max_nxt;
  logic [BIN_W-1:0]   r_peak, w_peak_nxt;
  logic [HGT_W-1:0]   r_height, w_height_nxt;
  logic [SMP_W-1:0]   r_buf [64];

  logic               w_wr_en;
  logic [SMP_W-1:0]   w_s_in;
  logic [SMP_W-1:0]   w_x;
  logic [10:0]        w_kn;
  logic [IDX_W-1:0]   w_idx;
  logic [TW_W-1:0]    w_cos, w_sin;
  logic [ACC_W-1:0]   w_x_ext, w_cos_ext, w_sin_ext;
  logic [ACC_W-1:0]   w_re_term, w_im_term;
  logic [ACC_W-1:0]   w_abs_re, w_abs_im, w_mag;

  // Quarter-wave table: round(127*cos(2*pi*j/64)) for j = 0..16
  function automatic logic [TW_W-1:0] qcos(input logic [4:0] j);
    case (j)
      5'd0:    return 8'd127;
      5'd1:    return 8'd126;
      5'd2:    return 8'd125;
      5'd3:    return 8'd122;
      5'd4:    return 8'd117;
      5'd5:    return 8'd112;
      5'd6:    return 8'd106;
      5'd7:    return 8'd98;
      5'd8:    return 8'd90;
      5'd9:    return 8'd81;
      5'd10:   return 8'd71;
      5'd11:   return 8'd60;
      5'd12:   return 8'd49;
      5'd13:   return 8'd37;
      5'd14:   return 8'd25;
      5'd15:   return 8'd12;
      default: return 8'd0;
    endcase
  endfunction

  function automatic logic [TW_W-1:0] cos_tw(input logic [IDX_W-1:0] i);
    logic [4:0] j;
    logic [4:0] jr;
    j  = {1'b0, i[3:0]};
    jr = 5'd16 - j;
    case (i[5:4])
      2'd0:    return qcos(j);
      2'd1:    return 8'd0 - qcos(jr);
      2'd2:    return 8'd0 - qcos(j);
      default: return qcos(jr);
    endcase
  endfunction

  // Offset-binary to two's complement is an MSB flip
  assign w_s_in  = {~mic_data[11], mic_data[10:0]};
  assign w_wr_en = (r_state == ST_FILL) && mic_clk;

  assign w_x   = r_buf[r_n];
  assign w_kn  = 11'(r_k) * 11'(r_n);
  assign w_idx = w_kn[IDX_W-1:0];
  assign w_cos = cos_tw(w_idx);
  assign w_sin = cos_tw(w_idx + 6'd48);

  // Sign-extend to accumulator width; the low ACC_W product bits are exact
  assign w_x_ext   = {{(ACC_W-SMP_W){w_x[SMP_W-1]}}, w_x};
  assign w_cos_ext = {{(ACC_W-TW_W){w_cos[TW_W-1]}}, w_cos};
  assign w_sin_ext = {{(ACC_W-TW_W){w_sin[TW_W-1]}}, w_sin};
  assign w_re_term = w_x_ext * w_cos_ext;
  assign w_im_term = w_x_ext * w_sin_ext;

  assign w_abs_re = r_re[ACC_W-1] ? (ACC_W'(0) - r_re) : r_re;
  assign w_abs_im = r_im[ACC_W-1] ? (ACC_W'(0) - r_im) : r_im;
  assign w_mag    = w_abs_re + w_abs_im;

  assign height = r_height;

  // Sample buffer, not reset
  always_ff @(posedge clk) begin
    if (w_wr_en) r_buf[r_cnt] <= w_s_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_FILL;
      r_cnt    <= '0;
      r_k      <= BIN_W'(1);
      r_n      <= '0;
      r_re     <= '0;
      r_im     <= '0;
      r_max    <= '0;
      r_peak   <= '0;
      r_height <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_k      <= w_k_nxt;
      r_n      <= w_n_nxt;
      r_re     <= w_re_nxt;
      r_im     <= w_im_nxt;
      r_max    <= w_max_nxt;
      r_peak   <= w_peak_nxt;
      r_height <= w_height_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_k_nxt      = r_k;
    w_n_nxt      = r_n;
    w_re_nxt     = r_re;
    w_im_nxt     = r_im;
    w_max_nxt    = r_max;
    w_peak_nxt   = r_peak;
    w_height_nxt = r_height;
    case (r_state)
      ST_FILL: begin
        if (mic_clk) begin
          w_cnt_nxt = r_cnt + 6'd1;
          if (r_cnt == 6'd63) begin
            w_state_nxt = ST_COMPUTE;
            w_k_nxt     = BIN_W'(1);
            w_n_nxt     = '0;
            w_re_nxt    = '0;
            w_im_nxt    = '0;
            w_max_nxt   = '0;
            w_peak_nxt  = '0;
          end
        end
      end
      ST_COMPUTE: begin
        w_re_nxt = r_re + w_re_term;
        w_im_nxt = r_im - w_im_term;
        w_n_nxt  = r_n + 6'd1;
        if (r_n == 6'd63) w_state_nxt = ST_CMP;
      end
      ST_CMP: begin
        if (w_mag > r_max) begin
          w_max_nxt  = w_mag;
          w_peak_nxt = r_k;
        end
        w_re_nxt = '0;
        w_im_nxt = '0;
        w_n_nxt  = '0;
        if (r_k == 5'd31) begin
          w_state_nxt = ST_UPDATE;
        end else begin
          w_k_nxt     = r_k + 5'd1;
          w_state_nxt = ST_COMPUTE;
        end
      end
      ST_UPDATE: begin
        w_height_nxt = (r_max >= ACC_W'(MAG_THRESH)) ?
                       HGT_W'(32'(r_peak) * HEIGHT_STEP) : '0;
        w_cnt_nxt    = '0;
        w_state_nxt  = ST_FILL;
      end
      default: w_state_nxt = ST_FILL;
    endcase
  end

endmodule

// File: tb/tb_get_height.sv
// Directed bench for get_height: tone frames through a scoreboard of expected heights.
module tb_get_height;

  logic        clk;
  logic        reset;
  logic        mic_clk;
  logic [11:0] mic_data;
  logic [9:0]  height;

  int          n_assert;
  int          n_fail;
  logic [9:0]  exp_q [$];
  logic [9:0]  last_h;

  get_height #(.MAG_THRESH(4096), .HEIGHT_STEP(15)) dut (
    .clk      (clk),
    .reset    (reset),
    .mic_clk  (mic_clk),
    .mic_data (mic_data),
    .height   (height)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] tone(input int bin, input int n);
    real x;
    int  r;
    x = 1000.0 * $cos(2.0 * 3.141592653589793 * real'(bin * n) / 64.0);
    r = (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
    return 12'(2048 + r);
  endfunction

  task automatic check(input string tag, input logic [9:0] expv);
    n_assert++;
    assert (height === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, height, expv);
    end
  endtask

  // Enter at a falling edge; leaves reset released at a falling edge
  task automatic do_reset(input string tag);
    @(negedge clk);
    reset   = 1'b0;
    mic_clk = 1'b0;
    #1;
    check(tag, 10'd0);
    repeat (2) @(negedge clk);
    reset  = 1'b1;
    last_h = 10'd0;
    exp_q.delete();
  endtask

  // Drives 64 samples (optionally with 1-cycle strobe gaps), then keeps junk strobed in
  task automatic drive_frame(input int bin, input bit stall, input bit push, input logic [9:0] expv);
    for (int n = 0; n < 64; n++) begin
      if (stall && n > 0) begin
        mic_clk  = 1'b0;
        mic_data = 12'($urandom);
        @(negedge clk);
      end
      mic_clk  = 1'b1;
      mic_data = tone(bin, n);
      @(negedge clk);
    end
    mic_clk  = 1'b1;
    mic_data = 12'($urandom);
    if (push) exp_q.push_back(expv);
  endtask

  // Height must hold until the edge 2016 cycles after sample 63, then take the new value
  task automatic wait_result(input string tag);
    logic [9:0] e;
    repeat (2015) @(negedge clk);
    check({tag, "_hold"}, last_h);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s: observed %0d expected none queued", tag, height);
    end else begin
      e = exp_q.pop_front();
      check(tag, e);
      last_h = e;
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    last_h   = 10'd0;
    reset    = 1'b0;
    mic_clk  = 1'b0;
    mic_data = 12'd2048;
    repeat (3) @(negedge clk);
    check("reset_state", 10'd0);
    reset = 1'b1;

    // DC input: every magnitude is zero
    mic_clk  = 1'b1;
    mic_data = 12'd2048;
    for (int i = 0; i < 2100; i++) begin
      @(negedge clk);
      if (i % 100 == 99) check("dc_zero", 10'd0);
    end
    do_reset("reset_after_dc");

    // Short ramp: no frame can complete in 500 cycles
    for (int i = 0; i < 500; i++) begin
      mic_clk  = 1'b1;
      mic_data = 12'(i % 250);
      @(negedge clk);
      if (i % 50 == 49) check("short_run", 10'd0);
    end
    do_reset("reset_after_short");

    // Back-to-back bin-8 frames with the strobe tied high
    drive_frame(8, 1'b0, 1'b1, 10'd120);
    wait_result("bin8_a");
    drive_frame(8, 1'b0, 1'b1, 10'd120);
    wait_result("bin8_b");

    // Top bin, then lowest bin with exact update timing
    drive_frame(31, 1'b0, 1'b1, 10'd465);
    wait_result("bin31");
    drive_frame(1, 1'b0, 1'b1, 10'd15);
    wait_result("bin1");

    // Abort a bin-8 frame about 1000 cycles into compute
    drive_frame(8, 1'b0, 1'b0, 10'd0);
    repeat (1000) @(negedge clk);
    do_reset("abort_async_zero");
    check("abort_held_zero", 10'd0);
    drive_frame(8, 1'b0, 1'b1, 10'd120);
    wait_result("after_abort");

    // 50% duty strobe
    drive_frame(4, 1'b1, 1'b1, 10'd60);
    wait_result("stall_bin4");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
